antilog_denormalizer: RTL and testbench

ANTILOG_DENORMALIZER -- requirements
Module: antilog_denormalizer

---
 rtl/mbm_pkg.sv | 15 +
 rtl/mbm_bias_comp.sv | 36 +++
 rtl/antilog_denormalizer.sv | 129 ++++++++++++
 tb/tb_antilog_denormalizer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mbm_pkg.sv
// mbm_pkg: definitions shared by the normalizing shifter and the antilog
// denormalizer. It holds the default datapath widths and the FSM state type.
package mbm_pkg;

    localparam int unsigned FRAC_W_DEF = 7;   // fraction width out of the normalizer
    localparam int unsigned K_W_DEF    = 4;   // characteristic width (sum of two 3-bit positions)
    localparam int unsigned OUT_W_DEF  = 16;  // product width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } mbm_state_t;

endpackage

// File: rtl/mbm_bias_comp.sv
// mbm_bias_comp: saturating bias compensation of the summed log fraction.
//   frac_eff_o = min(frac_i + BIAS_C, 2^FRAC_W - 1) when EN = 1,
//   frac_eff_o = frac_i                           when EN = 0.
// Ports:
//   frac_i      [FRAC_W-1:0]  summed log fraction
//   frac_eff_o  [FRAC_W-1:0]  effective fraction used by the denormalizer
import mbm_pkg::*;

module mbm_bias_comp #(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned BIAS_C = 8,
    parameter bit          EN     = 1'b1
) (
    input  logic [FRAC_W-1:0] frac_i,
    output logic [FRAC_W-1:0] frac_eff_o
);

    localparam logic [31:0] FRAC_MAX = 32'((64'd1 << FRAC_W) - 64'd1);

    logic [31:0] sum;

    // Sum is formed 32 bits wide so any BIAS_C value clamps correctly.
    assign sum = 32'(frac_i) + 32'(BIAS_C);

    always_comb begin
        frac_eff_o = frac_i;
        if (EN) begin
            if (sum > FRAC_MAX) begin
                frac_eff_o = '1;
            end else begin
                frac_eff_o = sum[FRAC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/antilog_denormalizer.sv
// antilog_denormalizer: turns a summed log value (characteristic k_in,
// fraction frac_in) back into a linear product by shifting {1, frac} left
// k times, one position per cycle, and keeping the integer part.
// k_in = all-ones (15) is the overflow code: result saturates to all-ones.
// Optional feature: define BIAS_COMP_EN to add BIAS_C to the fraction
// (saturating) before denormalization; latency and handshake are unchanged.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   frac_in [FRAC_W-1:0]  summed log fraction
//   k_in    [K_W-1:0]     summed characteristic
//   out_valid / out_ready result handshake; result held until accepted
//   result  [OUT_W-1:0]   denormalized product (held outside DONE)
//   sat                   result saturated (k_in = 15)
import mbm_pkg::*;

module antilog_denormalizer #(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned K_W    = K_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned BIAS_C = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic [K_W-1:0]    k_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              sat
);

`ifdef BIAS_COMP_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    // Integer part of the shifted mantissa sits above the FRAC_W fraction bits.
    localparam int unsigned   ACC_W = FRAC_W + OUT_W;
    localparam logic [K_W-1:0] K_SAT = '1;
    localparam logic [K_W-1:0] K_ONE = K_W'(1);

    mbm_state_t         state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [K_W-1:0]     cnt_q;
    logic [OUT_W-1:0]   result_q;
    logic               sat_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [FRAC_W-1:0]  frac_eff;
    logic [ACC_W-1:0]   acc_load;
    logic [ACC_W-1:0]   acc_shl;

    mbm_bias_comp #(
        .FRAC_W (FRAC_W),
        .BIAS_C (BIAS_C),
        .EN     (BIAS_EN)
    ) u_bias_comp (
        .frac_i     (frac_in),
        .frac_eff_o (frac_eff)
    );

    assign acc_load = ACC_W'({1'b1, frac_eff});
    assign acc_shl  = acc_q << 1;

    // Result/sat are captured on entry to DONE so they stay put afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= acc_load;
                        cnt_q      <= k_in;
                        in_ready_q <= 1'b0;
                        if (k_in == '0 || k_in == K_SAT) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            sat_q       <= (k_in == K_SAT);
                            result_q    <= (k_in == K_SAT) ? '1 : acc_load[FRAC_W +: OUT_W];
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= acc_shl;
                    cnt_q <= cnt_q - K_ONE;
                    // cnt_q == 1 means this edge performs the k-th shift.
                    if (cnt_q == K_ONE) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        sat_q       <= 1'b0;
                        result_q    <= acc_shl[FRAC_W +: OUT_W];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_antilog_denormalizer.sv
// Self-checking bench for antilog_denormalizer. A compact arithmetic model
// (product = floor((128 + frac_eff) * 2^k / 128), 0xFFFF/sat for k = 15,
// latency k+1 or 1) is compared against the DUT on every falling edge.
module tb_antilog_denormalizer;

    localparam int unsigned FW = 7;
    localparam int unsigned KW = 4;
    localparam int unsigned OW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] frac_in = '0;
    logic [KW-1:0] k_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] result;
    logic          sat;

    always #5 clk = ~clk;

    antilog_denormalizer #(
        .FRAC_W (FW),
        .K_W    (KW),
        .OUT_W  (OW),
        .BIAS_C (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frac_in   (frac_in),
        .k_in      (k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state shared between driver and compare process.
    bit        chk_en     = 1'b0;
    bit        m_busy     = 1'b0;
    int        m_age      = 0;
    int        m_lat      = 0;
    int        m_res      = 0;
    int        m_sat      = 0;
    int        m_lit      = -1;
    int        m_last_res = 0;
    int        m_last_sat = 0;

    function automatic int frac_eff_of(input int f);
`ifdef BIAS_COMP_EN
        return (f + 8 > 127) ? 127 : f + 8;
`else
        return f;
`endif
    endfunction

    function automatic int prod_of(input int f, input int k);
        if (k == 15) return 'hFFFF;
        return ((128 + frac_eff_of(f)) * (1 << k)) / 128;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0 || k == 15) ? 1 : k + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_busy) begin
                m_age++;
                chk("out_valid", int'(out_valid), int'(m_age >= m_lat));
                chk("in_ready_busy", int'(in_ready), 0);
                if (m_age >= m_lat) begin
                    chk("result", int'(result), m_res);
                    chk("sat", int'(sat), m_sat);
                    if (m_lit >= 0) chk("result_literal", int'(result), m_lit);
                    if (out_ready) begin
                        m_busy     = 1'b0;
                        m_last_res = m_res;
                        m_last_sat = m_sat;
                    end
                end
            end else begin
                chk("out_valid_idle", int'(out_valid), 0);
                chk("in_ready_idle", int'(in_ready), 1);
                chk("result_held", int'(result), m_last_res);
                chk("sat_held", int'(sat), m_last_sat);
            end
        end
    end

    task automatic start_op(input int f, input int k, input int hold, input int lit);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        frac_in   = FW'(f);
        k_in      = KW'(k);
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_res    = prod_of(f, k);
        m_sat    = (k == 15) ? 1 : 0;
        m_lat    = lat_of(k);
        m_lit    = lit;
        m_age    = 0;
        m_busy   = 1'b1;
    endtask

    task automatic do_op(input int f, input int k, input int hold, input int lit);
        int held;
        int guard;
        held  = 0;
        guard = 0;
        start_op(f, k, hold, lit);
        while (m_busy && guard < 60) begin
            @(posedge clk); #1;
            guard++;
            if (m_busy && m_age >= m_lat) begin
                if (held < hold) begin
                    // Operands offered while DONE must be ignored.
                    held++;
                    in_valid = ~in_valid;
                    frac_in  = FW'(held * 9);
                    k_in     = KW'(held);
                end else begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end
            end
        end
        if (m_busy) begin
            chk("handshake_timeout", 0, 1);
            m_busy = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op(0,   0,  0, 'h0001);
        do_op(64,  3,  0, 'h000C);
        do_op(127, 14, 0, 'h7F80);
        do_op(127, 15, 0, 'hFFFF);

        // Reset during SHIFT of a k=10 operation.
        start_op(5, 10, 0, -1);
        repeat (4) @(posedge clk);
        #2;
        rst_n      = 1'b0;
        m_busy     = 1'b0;
        m_last_res = 0;
        m_last_sat = 0;
        m_lit      = -1;
        #1;
        chk("async_rst_result", int'(result), 0);
        chk("async_rst_sat", int'(sat), 0);
        chk("async_rst_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);

        do_op(64,  3, 0, 'h000C);
        do_op(33,  5, 5, -1);
`ifdef BIAS_COMP_EN
        do_op(120, 7, 0, 'h00FF);
`else
        do_op(120, 7, 0, 'h00F8);
`endif
        do_op(5,   1, 0, 'h0002);

        for (int k = 0; k < 16; k++) begin
            do_op(k * 8 + 3, k, k % 3, -1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
